// File: rtl/demux_1to4_sched.sv
// One-entry holding-register scheduler that routes a valid/ready stream to four lanes,
// either round-robin or to a fixed lane.
module demux_1to4_sched #(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             mode,
  input  logic [1:0]       fix_sel,
  output logic [width-1:0] o0,
  output logic [width-1:0] o1,
  output logic [width-1:0] o2,
  output logic [width-1:0] o3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ready,
  output logic [1:0]       sel
);

  localparam int unsigned LANES   = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [width-1:0]     data_q,  data_d;
  logic [SEL_W-1:0]     sel_q,   sel_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                 full;
  logic                 in_fire;
  logic                 out_fire;

  // Handshake: a draining beat frees the holding register in the same cycle.
  always_comb begin
    full     = (state_q == HOLD);
    out_fire = full & o_ready[sel_q];
    i_ready  = ~full | out_fire;
    in_fire  = i_valid & i_ready;
  end

  // Next-state: capture overrides drain so a back-to-back beat replaces the old one.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    if (in_fire) begin
      state_d = HOLD;
      data_d  = i;
      sel_d   = mode ? fix_sel : rr_ptr_q;
      if (!mode) begin
        rr_ptr_d = rr_ptr_q + SEL_W'(1);
      end
    end else if (out_fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Lane drive is decoded straight from held state; idle lanes read zero.
  always_comb begin
    o_valid = full ? LANES'(4'b0001 << sel_q) : '0;
    o0      = o_valid[0] ? data_q : '0;
    o1      = o_valid[1] ? data_q : '0;
    o2      = o_valid[2] ? data_q : '0;
    o3      = o_valid[3] ? data_q : '0;
    sel     = sel_q;
  end

endmodule

// File: tb/tb_demux_1to4_sched.sv
// Directed bench for demux_1to4_sched with a queue scoreboard of expected lane/data beats.
module tb_demux_1to4_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] i;
  logic       i_valid;
  logic       i_ready;
  logic       mode;
  logic [1:0] fix_sel;
  logic [3:0] o0, o1, o2, o3;
  logic [3:0] o_valid;
  logic [3:0] o_ready;
  logic [1:0] sel;

  typedef struct {
    logic [1:0] lane;
    logic [3:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] rr;
  int         total;
  int         passed;

  demux_1to4_sched #(.width(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .mode    (mode),
    .fix_sel (fix_sel),
    .o0      (o0),
    .o1      (o1),
    .o2      (o2),
    .o3      (o3),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] lane_data(input logic [1:0] k);
    case (k)
      2'd0:    return o0;
      2'd1:    return o1;
      2'd2:    return o2;
      default: return o3;
    endcase
  endfunction

  // One clock: sample at the falling edge, update the scoreboard, then step past the rising edge.
  task automatic cycle(input string tag);
    exp_t       e;
    logic       exp_ir;
    logic [3:0] exp_ov;
    @(negedge clk);
    if (sb.size() > 0) begin
      e      = sb[0];
      exp_ov = 4'b0001 << e.lane;
      chk({tag, ".o_valid"}, 8'(o_valid), 8'(exp_ov));
      chk({tag, ".data"}, 8'(lane_data(e.lane)), 8'(e.data));
      chk({tag, ".sel"}, 8'(sel), 8'(e.lane));
      exp_ir = o_ready[e.lane];
      if (o_ready[e.lane]) void'(sb.pop_front());
    end else begin
      chk({tag, ".idle_valid"}, 8'(o_valid), 8'h00);
      exp_ir = 1'b1;
    end
    chk({tag, ".lanes_or"}, 8'(o0 | o1 | o2 | o3),
        (sb.size() > 0 || exp_ir != 1'b1 || o_valid != 4'b0000) ? 8'(o0 | o1 | o2 | o3) & 8'h0F : 8'h00);
    chk({tag, ".i_ready"}, 8'(i_ready), 8'(exp_ir));
    if (i_valid && exp_ir) begin
      e.data = i;
      e.lane = mode ? fix_sel : rr;
      if (!mode) rr = rr + 2'd1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".o_valid"}, 8'(o_valid), 8'h00);
    chk({tag, ".lanes"}, {o1, o0}, 8'h00);
    chk({tag, ".lanes_hi"}, {o3, o2}, 8'h00);
    chk({tag, ".sel"}, 8'(sel), 8'h00);
    chk({tag, ".i_ready"}, 8'(i_ready), 8'h01);
  endtask

  initial begin
    total = 0; passed = 0; rr = 2'd0;
    rst_n = 1'b0; i = '0; i_valid = 1'b0; mode = 1'b0; fix_sel = 2'd0; o_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin streaming A..E with all lanes ready.
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i = 4'(k + 1);
      cycle("rr_stream");
    end
    i_valid = 1'b0;
    cycle("rr_drain");
    chk("rr_empty", 8'(sb.size()), 8'h00);

    // Backpressure on lane 1: B stalls, C waits, then both move on the release edge.
    o_ready = 4'b1101;
    i_valid = 1'b1; i = 4'hB;
    cycle("bp_accept");
    i = 4'hC;
    for (int k = 0; k < 3; k++) begin
      cycle("bp_stall");
      chk("bp_stall_o1", 8'(o1), 8'h0B);
      chk("bp_stall_ir", 8'(i_ready), 8'h00);
    end
    o_ready = 4'b1111;
    cycle("bp_release");
    i_valid = 1'b0;
    chk("bp_c_on_o2", 8'(o2), 8'h0C);
    cycle("bp_c_drain");
    cycle("bp_idle");

    // Fixed route to lane 2, then resume round-robin where it left off (lane 3).
    mode = 1'b1; fix_sel = 2'd2;
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i = 4'(4'h6 + 4'(k));
      cycle("fix_stream");
    end
    mode = 1'b0; i = 4'hE;
    cycle("fix_to_rr");
    i_valid = 1'b0;
    chk("resume_lane3", 8'(o_valid), 8'h08);
    cycle("resume_drain");
    cycle("resume_idle");

    // Mid-hold changes on lane 3 must not disturb the held beat.
    o_ready = 4'b0111; mode = 1'b1; fix_sel = 2'd3;
    i_valid = 1'b1; i = 4'h9;
    cycle("mh_accept");
    mode = 1'b0; fix_sel = 2'd0; i = 4'h6;
    cycle("mh_hold0");
    mode = 1'b1; fix_sel = 2'd1; i = 4'h3;
    cycle("mh_hold1");
    chk("mh_o3", 8'(o3), 8'h09);
    chk("mh_ov", 8'(o_valid), 8'h08);
    i_valid = 1'b0; mode = 1'b0; o_ready = 4'b1111;
    cycle("mh_release");
    cycle("mh_idle");

    // Reset while holding: outputs clear without a clock edge, round-robin restarts at lane 0.
    o_ready = 4'b0000;
    i_valid = 1'b1; i = 4'hA;
    cycle("rst_accept");
    i_valid = 1'b0;
    cycle("rst_hold");
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    sb.delete();
    rr = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 4'b1111;
    i_valid = 1'b1; i = 4'h5;
    cycle("post_rst");
    i_valid = 1'b0;
    chk("post_rst_lane0", 8'(o_valid), 8'h01);
    cycle("post_rst_drain");
    cycle("post_rst_idle");
    chk("final_empty", 8'(sb.size()), 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
